// File: rtl/add_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
package add_pkg;

    function automatic int slice_w(input int n, input int stages);
        return n / stages;
    endfunction

    typedef struct packed {
        logic c_out;
        logic ovf;
        logic zero;
    } flags_t;

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result stream bundle for the pipelined CLA adder.
interface pipelined_cla_adder_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] s;
    logic         c_out;
    logic         ovf;
    logic         zero;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, s, c_out, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, s, c_out, ovf, zero
    );
endinterface

// File: rtl/cla_slice.sv
// Combinational W-bit carry-lookahead slice; also exposes the carry into the MSB.
module cla_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] s,
    output logic         c_out,
    output logic         c_msb
);
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;
    logic         gg;
    logic         pp;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is a flat sum of generate terms, not a ripple chain.
    always_comb begin
        c    = '0;
        gg   = 1'b0;
        pp   = 1'b0;
        c[0] = c_in;
        for (int i = 0; i < W; i++) begin
            gg = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                gg = gg | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = gg | (pp & c_in);
        end
    end

    assign s     = p ^ c[W-1:0];
    assign c_out = c[W];
    assign c_msb = c[W-1];
endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor: one W-bit slice per stage, skewed operands,
// de-skewed results, single global enable for backpressure.
module pipelined_cla_adder
    import add_pkg::*;
#(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pipelined_cla_adder_if.slave bus
);
    localparam int W = slice_w(N, STAGES);
    localparam int L = STAGES - 1;

    typedef struct packed {
        logic [N-1:0] s;
        flags_t       f;
    } beat_t;

    if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_cla_adder: N must be a multiple of STAGES, 1 <= STAGES <= N");
    end

    // a_q/b_q[k]: operands entering stage k (upper slices still pending).
    // lo_q[k]: result slices already produced below slice k.
    logic [STAGES:0] vld_pipe;
    logic [N-1:0]    a_q   [STAGES];
    logic [N-1:0]    b_q   [STAGES];
    logic [N-1:0]    lo_q  [STAGES];
    logic            cy_q  [STAGES];
    logic [W-1:0]    sl_s  [STAGES];
    logic            sl_co [STAGES];
    logic            sl_cm [STAGES];
    logic [N-1:0]    s_full;
    beat_t           res_q;
    logic            en;

    assign en            = !vld_pipe[STAGES] || bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.s         = res_q.s;
    assign bus.c_out     = res_q.f.c_out;
    assign bus.ovf       = res_q.f.ovf;
    assign bus.zero      = res_q.f.zero;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        cla_slice #(.W(W)) u_slice (
            .a     (a_q[k][k*W +: W]),
            .b     (b_q[k][k*W +: W]),
            .c_in  (cy_q[k]),
            .s     (sl_s[k]),
            .c_out (sl_co[k]),
            .c_msb (sl_cm[k])
        );
    end

    always_comb begin
        s_full             = lo_q[L];
        s_full[L*W +: W]   = sl_s[L];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            res_q    <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= '0;
                b_q[k]  <= '0;
                lo_q[k] <= '0;
                cy_q[k] <= 1'b0;
            end
        end else if (en) begin
            vld_pipe <= {vld_pipe[STAGES-1:0], bus.in_valid};
            // Subtract folds into add: invert B and force the carry-in.
            a_q[0]   <= bus.a;
            b_q[0]   <= bus.sub ? ~bus.b : bus.b;
            cy_q[0]  <= bus.sub | bus.c_in;
            lo_q[0]  <= '0;
            for (int k = 0; k < L; k++) begin
                a_q[k+1]             <= a_q[k];
                b_q[k+1]             <= b_q[k];
                cy_q[k+1]            <= sl_co[k];
                lo_q[k+1]            <= lo_q[k];
                lo_q[k+1][k*W +: W]  <= sl_s[k];
            end
            res_q.s       <= s_full;
            res_q.f.c_out <= sl_co[L];
            res_q.f.ovf   <= sl_co[L] ^ sl_cm[L];
            res_q.f.zero  <= (s_full == '0);
        end
    end
endmodule
